// File: rtl/cart_pkg.sv
// Shared definitions for the MBC1 cartridge responder: console memory map,
// MBC1 register-window decode and the responder FSM states.
package cart_pkg;

  localparam logic [15:0] ROM0_BASE = 16'h0000;
  localparam logic [15:0] ROMX_BASE = 16'h4000;
  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] SRAM_BASE = 16'hA000;
  localparam logic [15:0] WRAM_BASE = 16'hC000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_HOLD,
    ST_WR_REQ
  } state_e;

  typedef enum logic [2:0] {
    MBC_NONE,
    MBC_RAM_EN,
    MBC_BANK_LO,
    MBC_BANK_HI,
    MBC_MODE
  } mbc_reg_e;

  // Writes anywhere in the ROM window land on one of four 8 KiB register windows.
  function automatic mbc_reg_e mbc_reg_decode(input logic [15:0] addr);
    mbc_reg_e sel;
    if (addr >= VRAM_BASE)                   sel = MBC_NONE;
    else if (addr < ROM0_BASE + 16'h2000)    sel = MBC_RAM_EN;
    else if (addr < ROMX_BASE)               sel = MBC_BANK_LO;
    else if (addr < ROMX_BASE + 16'h2000)    sel = MBC_BANK_HI;
    else                                     sel = MBC_MODE;
    return sel;
  endfunction

  function automatic logic is_rom(input logic [15:0] addr);
    return addr < VRAM_BASE;
  endfunction

  function automatic logic is_rom0(input logic [15:0] addr);
    return addr < ROMX_BASE;
  endfunction

  function automatic logic is_sram(input logic [15:0] addr);
    return (addr >= SRAM_BASE) && (addr < WRAM_BASE);
  endfunction

endpackage

// File: rtl/cart_strobe_sync.sv
// N-stage synchronizer for an active-low console strobe, with single-cycle
// rise/fall pulses taken from the synchronized level.
module cart_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Strobes idle high, so the chain resets to the inactive level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cart_responder.sv
// Cartridge-side MBC1 responder: synchronizes console strobes, keeps the bank
// registers and serves ROM/SRAM accesses from backing memory via req/ack.
module cart_responder
  import cart_pkg::*;
#(
  parameter int ROM_ADDR_W  = 21,
  parameter int RAM_ADDR_W  = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           cart_address,
  input  logic [7:0]            cart_data_in,
  output logic [7:0]            cart_data_out,
  output logic                  cart_data_oe,
  input  logic                  cart_w_enable_l,
  input  logic                  cart_r_enable_l,
  input  logic                  cart_cs_sram_l,
  output logic                  mem_req,
  output logic                  mem_sel,
  output logic                  mem_we,
  output logic [ROM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  output logic [6:0]            rom_bank,
  output logic                  ram_enabled
);

  logic rdSync, rdFall, unusedRdRise;
  logic wrSync, wrRise, unusedWrFall;
  logic csSync, unusedCsRise, unusedCsFall;

  cart_strobe_sync #(.STAGES(SYNC_STAGES)) uRdSync (
    .clock(clock), .reset(reset), .async_i(cart_r_enable_l),
    .sync_o(rdSync), .rise_o(unusedRdRise), .fall_o(rdFall));
  cart_strobe_sync #(.STAGES(SYNC_STAGES)) uWrSync (
    .clock(clock), .reset(reset), .async_i(cart_w_enable_l),
    .sync_o(wrSync), .rise_o(wrRise), .fall_o(unusedWrFall));
  cart_strobe_sync #(.STAGES(SYNC_STAGES)) uCsSync (
    .clock(clock), .reset(reset), .async_i(cart_cs_sram_l),
    .sync_o(csSync), .rise_o(unusedCsRise), .fall_o(unusedCsFall));

  function automatic logic [ROM_ADDR_W-1:0] romXlate(input logic [13:0] off, input logic low,
                                                     input logic m, input logic [1:0] hi,
                                                     input logic [4:0] lo);
    logic [20:0] full;
    if (low) full = m ? {hi, 5'd0, off} : {7'd0, off};
    else     full = {hi, lo, off};
    return full[ROM_ADDR_W-1:0];
  endfunction

  function automatic logic [ROM_ADDR_W-1:0] sramXlate(input logic [12:0] off, input logic m,
                                                      input logic [1:0] hi);
    logic [14:0]           full;
    logic [ROM_ADDR_W-1:0] r;
    full = {(m ? hi : 2'b00), off};
    r = '0;
    r[RAM_ADDR_W-1:0] = full[RAM_ADDR_W-1:0];
    return r;
  endfunction

  logic [15:0] addrShadow_q;
  logic [7:0]  dataShadow_q;
  logic        csShadow_q;

  // Writes are acted on after /WR rises, so the bus is captured while a strobe is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addrShadow_q <= '0;
      dataShadow_q <= '0;
      csShadow_q   <= 1'b1;
    end else if (!rdSync || !wrSync) begin
      addrShadow_q <= cart_address;
      dataShadow_q <= cart_data_in;
      csShadow_q   <= csSync;
    end
  end

  state_e                state_q, state_d;
  logic                  ramEn_q, ramEn_d, mode_q, mode_d;
  logic [4:0]            bankLo_q, bankLo_d;
  logic [1:0]            bankHi_q, bankHi_d;
  logic                  pend_q, pend_d, pendCs_q, pendCs_d;
  logic [15:0]           pendAddr_q, pendAddr_d;
  logic [7:0]            pendData_q, pendData_d;
  logic                  memReq_q, memReq_d, memSel_q, memSel_d, memWe_q, memWe_d;
  logic [ROM_ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [7:0]            memWdata_q, memWdata_d, dataOut_q, dataOut_d;
  logic                  oe_q, oe_d, abort_q, abort_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ramEn_q    <= 1'b0;
      mode_q     <= 1'b0;
      bankLo_q   <= 5'd1;
      bankHi_q   <= 2'd0;
      pend_q     <= 1'b0;
      pendCs_q   <= 1'b1;
      pendAddr_q <= '0;
      pendData_q <= '0;
      memReq_q   <= 1'b0;
      memSel_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      dataOut_q  <= '0;
      oe_q       <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramEn_q    <= ramEn_d;
      mode_q     <= mode_d;
      bankLo_q   <= bankLo_d;
      bankHi_q   <= bankHi_d;
      pend_q     <= pend_d;
      pendCs_q   <= pendCs_d;
      pendAddr_q <= pendAddr_d;
      pendData_q <= pendData_d;
      memReq_q   <= memReq_d;
      memSel_q   <= memSel_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      dataOut_q  <= dataOut_d;
      oe_q       <= oe_d;
      abort_q    <= abort_d;
    end
  end

  logic        doWrite, wCs;
  logic [15:0] wAddr;
  logic [7:0]  wData;
  mbc_reg_e    mbcSel;

  always_comb begin
    state_d    = state_q;
    ramEn_d    = ramEn_q;
    mode_d     = mode_q;
    bankLo_d   = bankLo_q;
    bankHi_d   = bankHi_q;
    pend_d     = pend_q;
    pendCs_d   = pendCs_q;
    pendAddr_d = pendAddr_q;
    pendData_d = pendData_q;
    memReq_d   = memReq_q;
    memSel_d   = memSel_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    dataOut_d  = dataOut_q;
    oe_d       = oe_q;
    abort_d    = abort_q;
    doWrite    = 1'b0;
    wAddr      = pendAddr_q;
    wData      = pendData_q;
    wCs        = pendCs_q;

    // A parked write wins over a fresh strobe; a fresh write is parked if it can't go now.
    if (state_q == ST_IDLE) begin
      if (pend_q) begin
        doWrite = 1'b1;
        pend_d  = 1'b0;
      end else if (wrRise) begin
        doWrite = 1'b1;
        wAddr   = addrShadow_q;
        wData   = dataShadow_q;
        wCs     = csShadow_q;
      end
    end
    if (wrRise && (state_q != ST_IDLE || pend_q)) begin
      pend_d     = 1'b1;
      pendAddr_d = addrShadow_q;
      pendData_d = dataShadow_q;
      pendCs_d   = csShadow_q;
    end

    mbcSel = mbc_reg_decode(wAddr);

    case (state_q)
      ST_IDLE: begin
        if (doWrite) begin
          case (mbcSel)
            MBC_RAM_EN:  ramEn_d  = (wData[3:0] == 4'hA);
            MBC_BANK_LO: bankLo_d = (wData[4:0] == 5'd0) ? 5'd1 : wData[4:0];
            MBC_BANK_HI: bankHi_d = wData[1:0];
            MBC_MODE:    mode_d   = wData[0];
            default: begin
              if (is_sram(wAddr) && !wCs && ramEn_q) begin
                state_d    = ST_WR_REQ;
                memReq_d   = 1'b1;
                memSel_d   = 1'b1;
                memWe_d    = 1'b1;
                memAddr_d  = sramXlate(wAddr[12:0], mode_q, bankHi_q);
                memWdata_d = wData;
              end
            end
          endcase
        end else if (rdFall) begin
          if (is_rom(cart_address)) begin
            state_d   = ST_RD_REQ;
            memReq_d  = 1'b1;
            memSel_d  = 1'b0;
            memWe_d   = 1'b0;
            memAddr_d = romXlate(cart_address[13:0], is_rom0(cart_address), mode_q,
                                 bankHi_q, bankLo_q);
          end else if (is_sram(cart_address) && !csSync) begin
            if (ramEn_q) begin
              state_d   = ST_RD_REQ;
              memReq_d  = 1'b1;
              memSel_d  = 1'b1;
              memWe_d   = 1'b0;
              memAddr_d = sramXlate(cart_address[12:0], mode_q, bankHi_q);
            end else begin
              state_d   = ST_RD_HOLD;
              dataOut_d = 8'hFF;
              oe_d      = 1'b1;
            end
          end
        end
      end
      ST_RD_REQ: begin
        // Once /RD has gone away the data is unwanted, but the memory still owes an ack.
        if (mem_ack) begin
          memReq_d = 1'b0;
          abort_d  = 1'b0;
          if (abort_q || rdSync) begin
            state_d = ST_IDLE;
          end else begin
            dataOut_d = mem_rdata;
            oe_d      = 1'b1;
            state_d   = ST_RD_HOLD;
          end
        end else if (rdSync) begin
          abort_d = 1'b1;
        end
      end
      ST_RD_HOLD: begin
        if (rdSync) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (mem_ack) begin
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cart_data_out = dataOut_q;
  assign cart_data_oe  = oe_q;
  assign mem_req       = memReq_q;
  assign mem_sel       = memSel_q;
  assign mem_we        = memWe_q;
  assign mem_addr      = memAddr_q;
  assign mem_wdata     = memWdata_q;
  assign rom_bank      = {bankHi_q, bankLo_q};
  assign ram_enabled   = ramEn_q;

endmodule
